bk_test_nch: RTL
================

BK_TEST_NCH -- requirements
Module: bk_test_nch

Interface
REQ-001 Parameter CH_NUM, default 4, number of breakdown-test pulse channels (1..16).
REQ-002 Parameter CNT_W, default 19, period counter width.
REQ-003 Parameter PULSE_W, default 875, pulse high time in clocks (35 us at 25 MHz).
REQ-004 Parameter PERIOD, default 250000, pulse repetition period in clocks (10 ms).
REQ-005 Parameter STAGGER, default 62500, phase offset in clocks between channel k and channel k+1.
REQ-006 i_clk_25m  in  1  25 MHz clock; single clock domain.
REQ-007 i_rst  in  1  reset, synchronous, active-high.
REQ-008 i_start  in  1  start request; one-cycle pulse or level.
REQ-009 i_stop  in  1  abort request.
REQ-010 i_ch_en  in  CH_NUM  per-channel enable, latched at start.
REQ-011 i_burst_num  in  8  number of periods to run; 0 = continuous; latched at start.
REQ-012 o_bk_pulse  out  CH_NUM  registered per-channel test pulses.
REQ-013 o_busy  out  1  high while in RUN.
REQ-014 o_done  out  1  one-cycle pulse on burst completion.
REQ-015 o_period_cnt  out  8  completed periods in the current run, saturating at 255.

Function
REQ-016 The FSM SHALL have states IDLE and RUN; o_done is a registered flag, not a state.
REQ-017 IDLE->RUN SHALL occur when i_start=1 and i_stop=0; i_ch_en and i_burst_num are latched, the period counter is set to 0, and o_period_cnt is cleared on the same edge.
REQ-018 i_start in RUN SHALL be ignored; latched config SHALL NOT change mid-run.
REQ-019 In RUN the period counter SHALL increment by 1 per clock and wrap from PERIOD-1 to 0.
REQ-020 Channel k output SHALL be high exactly when it is latched-enabled and counter is in [k*STAGGER, k*STAGGER+PULSE_W-1]; registered, so with i_start at edge T, channel 0 is high for cycles T+1..T+PULSE_W.
REQ-021 On every wrap, o_period_cnt SHALL increment (saturating at 255).
REQ-022 If latched burst_num != 0 and the wrap completes period burst_num, the FSM SHALL return to IDLE, assert o_done for one cycle, and drive all outputs low.
REQ-023 i_stop in RUN SHALL return to IDLE on the next edge with all o_bk_pulse low and no o_done; i_stop wins over a simultaneous i_start or burst end.
REQ-024 A channel with i_ch_en=0 at start SHALL stay low for the whole run.
REQ-025 Parameter legality SHALL be checked at elaboration: (CH_NUM-1)*STAGGER+PULSE_W <= PERIOD, PERIOD <= 2**CNT_W, PULSE_W >= 1; violation is a fatal error.

Reset
REQ-026 i_rst SHALL override all inputs: state IDLE, counter 0, o_bk_pulse all 0, o_busy 0, o_done 0, o_period_cnt 0.
REQ-027 Reset asserted mid-pulse SHALL drop every output low on the next edge.

Configuration
REQ-028 Macro BK_FB_CHECK_EN SHALL add input i_bk_fb[CH_NUM] and output o_fb_err[CH_NUM].
REQ-029 With BK_FB_CHECK_EN, o_fb_err[k] SHALL set (sticky) at the last cycle of channel k's enabled pulse window if i_bk_fb[k] was not sampled high during that window; cleared by reset or an accepted start.
REQ-030 Without BK_FB_CHECK_EN, these ports and their logic SHALL be absent; pulse behaviour is unchanged.

Structure
REQ-031 Package bk_test_pkg SHALL hold the FSM state enum and the default PULSE_W/PERIOD/STAGGER constants.
REQ-032 The per-channel window compare and fb check SHALL be a sub-module bk_ch_win, instantiated CH_NUM times.

Verification
REQ-033 Defaults, all channels enabled, burst 0, start at T -> ch0 high T+1..T+875; ch1 high T+62501..T+63375; repeats at +250000.
REQ-034 PERIOD=100, PULSE_W=5, STAGGER=20, burst 3 -> exactly 3 pulses per channel; o_done high at T+300 only; o_period_cnt=3; o_busy low after.
REQ-035 i_ch_en=4'b0101 -> ch1 and ch3 stay 0 for the whole run; toggling i_ch_en mid-run has no effect.
REQ-036 i_stop during a ch0 pulse (cycle T+3) -> all outputs 0 from T+4, no o_done; simultaneous i_start+i_stop in IDLE -> remains IDLE.
REQ-037 i_rst at T+2 while ch0 is high -> all outputs 0 at T+3; o_period_cnt 0.
REQ-038 BK_FB_CHECK_EN, i_bk_fb[2] held 0, others echo pulses -> only o_fb_err[2] sets at the end of ch2's first window; cleared by the next start.

Source files
------------

// File: rtl/bk_test_pkg.sv
// Breakdown-test pulse generator: shared FSM state type and default pulse timing.
package bk_test_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } bk_state_e;

    localparam int unsigned BK_PULSE_W = 875;     // 35 us at 25 MHz
    localparam int unsigned BK_PERIOD  = 250000;  // 10 ms at 25 MHz
    localparam int unsigned BK_STAGGER = 62500;

endpackage

// File: rtl/bk_ch_win.sv
// One channel's pulse-window compare. With BK_FB_CHECK_EN it also flags (sticky)
// any enabled pulse window in which the returned feedback never went high.
module bk_ch_win #(
    parameter int unsigned CNT_W   = 19,
    parameter int unsigned LO      = 0,
    parameter int unsigned PULSE_W = 875,
    parameter int unsigned PERIOD  = 250000
) (
`ifdef BK_FB_CHECK_EN
    input  logic             i_clk_25m,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_pulse,
    input  logic             i_fb,
    output logic             o_err,
`endif
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_en,
    output logic             o_hit
);

    localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(LO);
    localparam logic [CNT_W:0]   WIN_LEN = (CNT_W + 1)'(PULSE_W);

    logic [CNT_W-1:0] offset;

    // Offset wraps to a large value below LO, so one unsigned compare covers both bounds.
    assign offset = i_cnt - WIN_LO;
    assign o_hit  = i_en && ({1'b0, offset} < WIN_LEN);

`ifdef BK_FB_CHECK_EN
    // The pulse lags the counter by one clock, so its last cycle sees cnt = LO + PULSE_W.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((LO + PULSE_W) % PERIOD);

    logic seen_q, seen_d;
    logic err_q, err_d;
    logic last;

    always_comb begin
        last   = i_pulse && (i_cnt == LAST_CNT);
        seen_d = i_pulse && !last && (seen_q || i_fb);
        err_d  = i_clr ? 1'b0 : (err_q || (last && !seen_q && !i_fb));
    end

    always_ff @(posedge i_clk_25m) begin
        if (i_rst) begin
            seen_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            seen_q <= seen_d;
            err_q  <= err_d;
        end
    end

    assign o_err = err_q;
`endif

endmodule

// File: rtl/bk_test_nch.sv
// Multi-channel breakdown-test pulse generator with staggered channel windows.
// Define BK_FB_CHECK_EN to add per-channel pulse feedback checking (i_bk_fb / o_fb_err).
module bk_test_nch
    import bk_test_pkg::*;
#(
    parameter int unsigned CH_NUM  = 4,
    parameter int unsigned CNT_W   = 19,
    parameter int unsigned PULSE_W = BK_PULSE_W,
    parameter int unsigned PERIOD  = BK_PERIOD,
    parameter int unsigned STAGGER = BK_STAGGER
) (
    input  logic              i_clk_25m,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [CH_NUM-1:0] i_ch_en,
    input  logic [7:0]        i_burst_num,
`ifdef BK_FB_CHECK_EN
    input  logic [CH_NUM-1:0] i_bk_fb,
    output logic [CH_NUM-1:0] o_fb_err,
`endif
    output logic [CH_NUM-1:0] o_bk_pulse,
    output logic              o_busy,
    output logic              o_done,
    output logic [7:0]        o_period_cnt
);

    if ((CH_NUM < 1) || (CH_NUM > 16) || (PULSE_W < 1) ||
        ((CH_NUM - 1) * STAGGER + PULSE_W > PERIOD) ||
        (longint'(PERIOD) > (64'd1 << CNT_W))) begin : g_param_chk
        $fatal(1, "bk_test_nch: illegal CH_NUM/CNT_W/PULSE_W/PERIOD/STAGGER combination");
    end

    bk_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_NUM-1:0] en_q, en_d;
    logic [7:0]        burst_q, burst_d;
    logic [7:0]        pcnt_q, pcnt_d;
    logic [CH_NUM-1:0] pulse_q, pulse_d;
    logic              done_q, done_d;
    logic [CH_NUM-1:0] hit;
    logic              wrap;

    assign wrap = (cnt_q == CNT_W'(PERIOD - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        burst_d = burst_q;
        pcnt_d  = pcnt_q;
        pulse_d = '0;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_start && !i_stop) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    en_d    = i_ch_en;
                    burst_d = i_burst_num;
                    pcnt_d  = '0;
                end
            end
            StRun: begin
                if (i_stop) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    pulse_d = hit;
                    cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
                    if (wrap) begin
                        if (pcnt_q != 8'hff) pcnt_d = pcnt_q + 8'd1;
                        // pcnt_q < burst_q here, so the 8-bit sum cannot overflow.
                        if ((burst_q != 8'd0) && (pcnt_q + 8'd1 == burst_q)) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                            pulse_d = '0;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk_25m) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            en_q    <= '0;
            burst_q <= '0;
            pcnt_q  <= '0;
            pulse_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            burst_q <= burst_d;
            pcnt_q  <= pcnt_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
        end
    end

`ifdef BK_FB_CHECK_EN
    logic start_acc;
    assign start_acc = (state_q == StIdle) && i_start && !i_stop;
`endif

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
`ifdef BK_FB_CHECK_EN
        bk_ch_win #(
            .CNT_W  (CNT_W),
            .LO     (k * STAGGER),
            .PULSE_W(PULSE_W),
            .PERIOD (PERIOD)
        ) u_win (
            .i_clk_25m(i_clk_25m),
            .i_rst    (i_rst),
            .i_clr    (start_acc),
            .i_pulse  (pulse_q[k]),
            .i_fb     (i_bk_fb[k]),
            .o_err    (o_fb_err[k]),
            .i_cnt    (cnt_q),
            .i_en     (en_q[k]),
            .o_hit    (hit[k])
        );
`else
        bk_ch_win #(
            .CNT_W  (CNT_W),
            .LO     (k * STAGGER),
            .PULSE_W(PULSE_W),
            .PERIOD (PERIOD)
        ) u_win (
            .i_cnt(cnt_q),
            .i_en (en_q[k]),
            .o_hit(hit[k])
        );
`endif
    end

    assign o_bk_pulse   = pulse_q;
    assign o_busy       = (state_q == StRun);
    assign o_done       = done_q;
    assign o_period_cnt = pcnt_q;

endmodule
